// File: rtl/bcd_entry_register.sv
// bcd_entry_register: calculator-style multi-digit BCD entry register.
// Newest digit enters at the least-significant position. Supports clear,
// backspace, leading-zero suppression and error flagging of rejected entries.
// Optional display scan logic is built when BCD_ENTRY_SCAN_EN is defined;
// otherwise scan_sel is tied to 0 and scan_digit to blank (4'hF).
`timescale 1ns/1ps

module bcd_entry_register #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  digit_in,
    input  logic                        digit_valid,
    input  logic                        clear,
    input  logic                        backspace,
    output logic [4*DIGITS-1:0]         value,
    output logic [$clog2(DIGITS+1)-1:0] count,
    output logic                        full,
    output logic                        err,
    output logic [DIGITS-1:0]           scan_sel,
    output logic [3:0]                  scan_digit
);

    localparam int CW = $clog2(DIGITS+1);

    // Full is a pure function of the registered digit count
    assign full = (count == CW'(DIGITS));

    // Entry state: clear beats backspace beats digit entry; err is a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clear) begin
                value <= '0;
                count <= '0;
            end else if (backspace) begin
                if (count != '0) begin
                    value <= value >> 4;
                    count <= count - CW'(1);
                end
            end else if (digit_valid) begin
                if (digit_in > 4'd9) begin
                    err <= 1'b1;
                end else if (full) begin
                    err <= 1'b1;
                end else if (!(digit_in == 4'd0 && count == '0)) begin
                    value <= {value[4*DIGITS-5:0], digit_in};
                    count <= count + CW'(1);
                end
            end
        end
    end

`ifdef BCD_ENTRY_SCAN_EN
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] scan_idx;

    // Free-running dwell divider; the position index advances on each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            scan_idx <= '0;
        end else if (div_cnt == DIV_W'(SCAN_DIV-1)) begin
            div_cnt  <= '0;
            scan_idx <= (scan_idx == IDX_W'(DIGITS-1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Select the current position and show its digit; unentered positions blank,
    // except a lone 0 at position 0 when nothing has been entered
    always_comb begin
        scan_sel           = '0;
        scan_sel[scan_idx] = 1'b1;
        scan_digit         = 4'hF;
        if (int'(scan_idx) < int'(count)) begin
            scan_digit = value[4*scan_idx +: 4];
        end else if (scan_idx == '0) begin
            scan_digit = 4'h0;
        end
    end
`else
    logic unused_scan_div;

    assign unused_scan_div = (SCAN_DIV >= 2);
    assign scan_sel        = '0;
    assign scan_digit      = 4'hF;
`endif

endmodule

// File: tb/tb_bcd_entry_register.sv
// tb_bcd_entry_register: scoreboard bench for bcd_entry_register (DIGITS=4, SCAN_DIV=4).
// Stimulus pushes expected state per cycle; a monitor pops and compares after each edge.
`timescale 1ns/1ps

module tb_bcd_entry_register;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        clear;
    logic        backspace;
    logic [15:0] value;
    logic [2:0]  count;
    logic        full;
    logic        err;
    logic [3:0]  scan_sel;
    logic [3:0]  scan_digit;

    typedef struct {
        logic [15:0] v;
        logic [2:0]  c;
        logic        e;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   scan_edges = 0;

    bcd_entry_register #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digit_in(digit_in),
        .digit_valid(digit_valid),
        .clear(clear),
        .backspace(backspace),
        .value(value),
        .count(count),
        .full(full),
        .err(err),
        .scan_sel(scan_sel),
        .scan_digit(scan_digit)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by monitor and reset checks
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's command at the falling edge and queue the expected result
    task automatic applyStimulus(input logic clr, input logic bs, input logic dv, input logic [3:0] d,
                                 input logic [15:0] ev, input logic [2:0] ec, input logic ee);
        exp_t x;
        @(negedge clk);
        clear       = clr;
        backspace   = bs;
        digit_valid = dv;
        digit_in    = d;
        x.v = ev;
        x.c = ec;
        x.e = ee;
        sb_q.push_back(x);
    endtask

    task automatic idle(input logic [15:0] ev, input logic [2:0] ec);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, ev, ec, 1'b0);
    endtask

    task automatic entry(input logic [3:0] d, input logic [15:0] ev, input logic [2:0] ec, input logic ee);
        applyStimulus(1'b0, 1'b0, 1'b1, d, ev, ec, ee);
    endtask

    task automatic checkScan(input string tag, input logic [15:0] ev, input logic [2:0] ec);
        logic [3:0] exp_sel;
        logic [3:0] exp_dig;
        int         idx;
`ifdef BCD_ENTRY_SCAN_EN
        idx     = (scan_edges / SCAN_DIV) % DIGITS;
        exp_sel = 4'b0001 << idx;
        if (idx < int'(ec))   exp_dig = ev[idx*4 +: 4];
        else if (idx == 0)    exp_dig = 4'h0;
        else                  exp_dig = 4'hF;
`else
        idx     = 0;
        exp_sel = 4'b0000;
        exp_dig = 4'hF;
`endif
        checkOutput({tag, "_scan_sel"}, 32'(scan_sel), 32'(exp_sel));
        checkOutput({tag, "_scan_digit"}, 32'(scan_digit), 32'(exp_dig));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_value"}, 32'(value), 32'h0);
        checkOutput({tag, "_count"}, 32'(count), 32'h0);
        checkOutput({tag, "_full"}, 32'(full), 32'h0);
        checkOutput({tag, "_err"}, 32'(err), 32'h0);
        checkScan(tag, 16'h0, 3'd0);
    endtask

    // Monitor: count scan edges since reset, then compare against the queued expectation
    always @(posedge clk) begin
        exp_t x;
        if (!rst_n) scan_edges = 0;
        else        scan_edges++;
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            checkOutput("value", 32'(value), 32'(x.v));
            checkOutput("count", 32'(count), 32'(x.c));
            checkOutput("full", 32'(full), 32'(x.c == 3'd4));
            checkOutput("err", 32'(err), 32'(x.e));
            checkScan("run", x.v, x.c);
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        backspace   = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        #1;
        checkReset("init_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic entry: 1,2,3
        entry(4'd1, 16'h0001, 3'd1, 1'b0);
        entry(4'd2, 16'h0012, 3'd2, 1'b0);
        entry(4'd3, 16'h0123, 3'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b0);

        // Leading zero suppressed, then 7
        entry(4'd0, 16'h0000, 3'd0, 1'b0);
        entry(4'd7, 16'h0007, 3'd1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b0);

        // Fill to full, then overflow is rejected
        entry(4'd9, 16'h0009, 3'd1, 1'b0);
        entry(4'd8, 16'h0098, 3'd2, 1'b0);
        entry(4'd7, 16'h0987, 3'd3, 1'b0);
        entry(4'd6, 16'h9876, 3'd4, 1'b0);
        entry(4'd5, 16'h9876, 3'd4, 1'b1);
        idle(16'h9876, 3'd4);
        entry(4'hB, 16'h9876, 3'd4, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b0);

        // Backspace, then all three commands together
        entry(4'd4, 16'h0004, 3'd1, 1'b0);
        entry(4'd5, 16'h0045, 3'd2, 1'b0);
        entry(4'd6, 16'h0456, 3'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 16'h0045, 3'd2, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 16'h0000, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b0);

        // Invalid digit, then backspace beating a digit strobe
        entry(4'hA, 16'h0000, 3'd0, 1'b1);
        idle(16'h0000, 3'd0);
        entry(4'd1, 16'h0001, 3'd1, 1'b0);
        entry(4'd2, 16'h0012, 3'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd5, 16'h0001, 3'd1, 1'b0);
        entry(4'd2, 16'h0012, 3'd2, 1'b0);

        // Hold 0x0012 across a full scan refresh
        for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) idle(16'h0012, 3'd2);

        // Reset mid-entry takes effect immediately
        entry(4'd3, 16'h0123, 3'd3, 1'b0);
        @(negedge clk);
        digit_valid = 1'b1;
        digit_in    = 4'd4;
        rst_n       = 1'b0;
        #1;
        checkReset("mid_reset");
        repeat (2) @(negedge clk);
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        rst_n       = 1'b1;
        entry(4'd8, 16'h0008, 3'd1, 1'b0);
        for (int i = 0; i < 6; i++) idle(16'h0008, 3'd1);

        // Drain the scoreboard with a bounded wait
        repeat (4) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            bad++;
            total++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
